// File: rtl/dmem_defs.sv
// Shared encodings for the data-memory access path: access sizes, arbiter FSM
// states and the default memory size.
package dmem_defs;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam int MEM_BYTES_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bytes touched by an access; the illegal encoding reports 1 and is rejected separately.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_HALF: size_nbytes = 3'd2;
      SIZE_WORD: size_nbytes = 3'd4;
      default:   size_nbytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Byte-lane merge for sub-word stores: replaces the low byte or half of the old
// word with right-justified store data; a word store passes wdata through.
module store_merge
  import dmem_defs::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = wdata;
    case (size)
      SIZE_BYTE: new_word = {old_word[31:8], wdata[7:0]};
      SIZE_HALF: new_word = {old_word[31:16], wdata[15:0]};
      default:   new_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the 256-byte data memory:
// bounds-checks requests, runs read-modify-write for sub-word stores.
module dmem_arbiter
  import dmem_defs::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_in,
  output logic        mem_wr,
  input  logic [31:0] mem_out
);

  state_t      state_q, state_d;
  logic        port_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        last_grant_q;

  logic        any_req;
  logic        grant_port;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [32:0] end_addr;
  logic        illegal;
  logic [31:0] merged;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    any_req    = req0 | req1;
    grant_port = (req0 && req1) ? ~last_grant_q : req1;
    sel_we     = grant_port ? we1    : we0;
    sel_size   = grant_port ? size1  : size0;
    sel_addr   = grant_port ? addr1  : addr0;
    sel_wdata  = grant_port ? wdata1 : wdata0;
    // 33-bit end address so that accesses near 0xFFFFFFFF cannot wrap into range.
    end_addr   = {1'b0, sel_addr} + {30'd0, size_nbytes(sel_size)} - 33'd1;
    illegal    = (sel_size == SIZE_BAD) || (end_addr > 33'(MEM_BYTES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (illegal)                      state_d = DONE;
          else if (!sel_we)                 state_d = READ;
          else if (sel_size == SIZE_WORD)   state_d = WRITE;
          else                              state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= SIZE_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (state_q == IDLE && any_req) begin
        port_q       <= grant_port;
        we_q         <= sel_we;
        size_q       <= sel_size;
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
        err_q        <= illegal;
        last_grant_q <= grant_port;
      end
      if (state_q == READ) data_q <= mem_out;
    end
  end

  store_merge u_store_merge (
    .old_word (data_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .new_word (merged)
  );

  // Memory pins follow the operand registers so they hold between accesses.
  always_comb begin
    mem_raddr = addr_q;
    mem_waddr = addr_q;
    mem_in    = merged;
    mem_wr    = (state_q == WRITE);
    ack0      = (state_q == DONE) && !port_q;
    ack1      = (state_q == DONE) && port_q;
    err       = (state_q == DONE) && err_q;
    rdata     = '0;
    if (state_q == DONE && !we_q && !err_q) begin
      case (size_q)
        SIZE_BYTE: rdata = {24'd0, data_q[7:0]};
        SIZE_HALF: rdata = {16'd0, data_q[15:0]};
        default:   rdata = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 256-byte little-endian
// memory (combinational read, word write on the falling edge).
module tb_dmem_arbiter;
  import dmem_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [1:0]  size0 = 2'b00, size1 = 2'b00;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, mem_wr;
  logic [31:0] rdata, mem_raddr, mem_waddr, mem_in, mem_out;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_count = 0;
  logic [7:0]  mem [256];
  logic        init_done = 1'b0;

  dmem_arbiter #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_in(mem_in),
    .mem_wr(mem_wr), .mem_out(mem_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      init_done <= 1'b1;
    end else if (mem_wr) begin
      for (int i = 0; i < 4; i++)
        if (({1'b0, mem_waddr} + 33'(i)) < 33'd256)
          mem[mem_waddr[7:0] + 8'(i)] <= mem_in[8*i +: 8];
    end
  end

  always @(negedge clk) if (mem_wr && !rst) wr_count <= wr_count + 1;

  always_comb begin
    mem_out = '0;
    for (int i = 0; i < 4; i++)
      if (({1'b0, mem_raddr} + 33'(i)) < 33'd256)
        mem_out[8*i +: 8] = mem[mem_raddr[7:0] + 8'(i)];
  end

  function automatic logic [31:0] memWord(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (!rst && (ack0 || ack1)) begin
      if (ack0 && ack1) checkOutput("ack_onehot", {30'd0, ack1, ack0}, 32'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("ack_port", {31'd0, ack1}, {31'd0, mon_e.port});
        checkOutput("err", {31'd0, err}, {31'd0, mon_e.err});
        checkOutput("rdata", rdata, mon_e.rdata);
      end
    end
  end

  task automatic drivePort(input logic port, input logic req, input logic we,
                           input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      req1 = req; we1 = we; size1 = size; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = req; we0 = we; size0 = size; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic dropReq(input logic port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic waitAck(input logic port, output int when, output bit ok);
    ok = 1'b0;
    when = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((port && ack1) || (!port && ack0)) begin
        ok = 1'b1;
        when = cyc;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL ack_timeout: got no ack on port %0d expected one within 20 cycles", port);
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    int  c0, when;
    bit  ok;
    @(posedge clk); #1;
    sb.push_back(exp_t'{port, exp_err, exp_rdata});
    drivePort(port, 1'b1, we, size, addr, wdata);
    c0 = cyc;
    waitAck(port, when, ok);
    if (ok) checkOutput("latency", 32'(when - c0), 32'(exp_lat));
    @(posedge clk); #1;
    dropReq(port);
  endtask

  task automatic tieLoads(input logic [31:0] a0, input logic [31:0] e0,
                          input logic [31:0] a1, input logic [31:0] e1);
    int  c0, t0, t1;
    bit  ok0, ok1;
    @(posedge clk); #1;
    sb.push_back(exp_t'{1'b0, 1'b0, e0});
    sb.push_back(exp_t'{1'b1, 1'b0, e1});
    drivePort(1'b0, 1'b1, 1'b0, SIZE_WORD, a0, 32'd0);
    drivePort(1'b1, 1'b1, 1'b0, SIZE_WORD, a1, 32'd0);
    c0 = cyc;
    waitAck(1'b0, t0, ok0);
    if (ok0) checkOutput("tie_first_latency", 32'(t0 - c0), 32'd2);
    @(posedge clk); #1;
    dropReq(1'b0);
    waitAck(1'b1, t1, ok1);
    if (ok0 && ok1) checkOutput("tie_gap", 32'(t1 - t0), 32'd3);
    @(posedge clk); #1;
    dropReq(1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_ack0", {31'd0, ack0}, 32'd0);
    checkOutput("reset_ack1", {31'd0, ack1}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("reset_mem_raddr", mem_raddr, 32'd0);
    checkOutput("reset_mem_waddr", mem_waddr, 32'd0);
    checkOutput("reset_mem_in", mem_in, 32'd0);

    $display("[TB] tie arbitration");
    tieLoads(32'h0, 32'h03020100, 32'h4, 32'h07060504);
    tieLoads(32'h8, 32'h0B0A0908, 32'h30, 32'h33323130);

    $display("[TB] word and sub-word stores");
    applyStimulus(1'b0, 1'b1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    checkOutput("mem_byte_10", {24'd0, mem[16]}, 32'hEF);
    applyStimulus(1'b0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    applyStimulus(1'b0, 1'b1, SIZE_BYTE, 32'h10, 32'h00000055, 1'b0, 32'h0, 3);
    applyStimulus(1'b0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0, 32'hDEADBE55, 2);
    applyStimulus(1'b0, 1'b0, SIZE_BYTE, 32'h13, 32'h0, 1'b0, 32'h000000DE, 2);
    applyStimulus(1'b1, 1'b1, SIZE_HALF, 32'h12, 32'hFFFF1234, 1'b0, 32'h0, 3);
    checkOutput("mem_word_14", memWord(20), 32'h1B1A1514 & 32'h00001514 | 32'h17160000);
    applyStimulus(1'b1, 1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0, 32'h1234BE55, 2);
    applyStimulus(1'b0, 1'b0, SIZE_HALF, 32'h12, 32'h0, 1'b0, 32'h00001234, 2);

    $display("[TB] boundary and illegal accesses");
    w0 = wr_count;
    applyStimulus(1'b0, 1'b0, SIZE_WORD, 32'd252, 32'h0, 1'b0, 32'hFFFEFDFC, 2);
    applyStimulus(1'b0, 1'b0, SIZE_WORD, 32'd253, 32'h0, 1'b1, 32'h0, 1);
    applyStimulus(1'b0, 1'b1, SIZE_HALF, 32'd255, 32'hBEEF, 1'b1, 32'h0, 1);
    checkOutput("mem_byte_255", {24'd0, mem[255]}, 32'hFF);
    applyStimulus(1'b1, 1'b0, SIZE_WORD, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0, 1);
    applyStimulus(1'b1, 1'b1, SIZE_BAD, 32'h40, 32'hCAFEF00D, 1'b1, 32'h0, 1);
    checkOutput("no_write_on_err", 32'(wr_count - w0), 32'd0);
    checkOutput("mem_word_40", memWord(64), 32'h43424140);

    $display("[TB] reset during write");
    @(posedge clk); #1;
    drivePort(1'b0, 1'b1, 1'b1, SIZE_WORD, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    checkOutput("pre_reset_mem_wr", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rst_ack0", {31'd0, ack0}, 32'd0);
    checkOutput("rst_ack1", {31'd0, ack1}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_mem_raddr", mem_raddr, 32'd0);
    checkOutput("rst_mem_waddr", mem_waddr, 32'd0);
    checkOutput("rst_mem_in", mem_in, 32'd0);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    checkOutput("mem_word_20", memWord(32), 32'h23222120);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the 256-byte data memory (`dmemnclk`). It shares the memory between port 0 (CPU load/store unit) and port 1 (loader/debug port) with round-robin arbitration. Sub-word stores are done as read-modify-write, and out-of-range accesses are rejected. It drives the memory's raddr/waddr/in/memwr pins and samples its combinational read data.

## Interface
Parameters:
- MEM_BYTES, 256, memory size in bytes; the last legal byte address is MEM_BYTES-1

Ports:
- clk  in  1  system clock; memory write commits on negedge
- rst  in  1  reset, asynchronous, active-high
- req0, req1  in  1  access request; held until ack
- we0, we1  in  1  1 = store, 0 = load
- size0, size1  in  2  00 byte, 01 half, 10 word; 11 is illegal
- addr0, addr1  in  32  byte address; unaligned access allowed
- wdata0, wdata1  in  32  store data, right-justified
- ack0, ack1  out  1  one-cycle completion pulse
- err  out  1  valid with ack: access rejected
- rdata  out  32  load data, zero-extended, valid with ack
- mem_raddr, mem_waddr  out  32  memory address pins
- mem_in  out  32  memory write data
- mem_wr  out  1  memory write enable
- mem_out  in  32  memory combinational read data

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - Arbitrates requests. If only one req is high, that port is granted. If both are high, the port other than last_grant is granted.
  - On grant: latch port, we, size, addr and wdata; update last_grant.
  - Then branch:
    - Illegal access → DONE with err=1.
    - Load → READ.
    - Word store → WRITE.
    - Byte/half store → READ.
  - Illegal access means size=11, or addr+nbytes-1 > MEM_BYTES-1, computed in 33 bits so addr 0xFFFFFFFF does not wrap.
- **READ**
  - Drive mem_raddr = addr.
  - At posedge, capture mem_out into the data register.
  - Load → DONE. Sub-word store → WRITE.
- **WRITE**
  - Drive mem_waddr = addr and mem_wr = 1.
  - mem_in = wdata for a word store.
  - For a sub-word store, mem_in = captured word with byte [7:0] (byte) or bytes [15:0] (half) replaced by wdata.
  - The memory commits at the negedge inside this cycle. → DONE.
- **DONE**
  - ack of the granted port = 1.
  - rdata = captured word masked to size: byte zero-extends [7:0], half zero-extends [15:0]. rdata = 0 on a store or on err.
  - → IDLE.
- Requester handshake: hold req and operands stable until it samples ack=1, then drop req the next cycle. If req is still high in IDLE, it counts as a new request.
- mem_wr decodes from the state register only; it is 0 in every state except WRITE.
- mem_raddr/mem_waddr/mem_in hold the latched values outside the active state; they do not return to 0.
- Reset mid-operation:
  - state → IDLE and mem_wr → 0 immediately.
  - If rst rises during WRITE before the negedge, no memory write occurs.
  - Any in-flight access is abandoned with no ack.
- No memory write ever occurs for an err access.

## Timing
- Reset values: state IDLE, ack0=ack1=0, err=0, rdata=0, mem_wr=0, mem_raddr=mem_waddr=mem_in=0, last_grant=1 (port 0 wins the first tie).
- Request sampled at edge N. Ack is high in the cycle after:
  - load: edge N+2
  - word store: edge N+2
  - sub-word store: edge N+3
  - err: edge N+1
- Throughput: with back-to-back loads from alternating ports, one ack every 3 cycles (IDLE, READ, DONE).
- A simultaneous request from the non-granted port waits; it is granted at the next IDLE.

## Structure
- Shared header/package `dmem_defs`:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings
  - FSM state encodings (2-bit)
  - MEM_BYTES default
- Sub-module `store_merge`: combinational byte-lane merge of old word, wdata and size into the new word. It is reused by future cache fill logic.
- The arbiter FSM and operand registers live in dmem_arbiter; the target size is about 180 RTL lines.

## Test plan
- Word store then load, port 0:
  - store addr=0x10, wdata=0xDEADBEEF → ack0 at N+2, mem byte 0x10=0xEF.
  - load addr=0x10 → rdata=0xDEADBEEF, err=0.
- Byte store into that word: size=00, addr=0x10, wdata=0x55 → ack at N+3; a following word load reads 0xDEADBE55. A byte load at 0x13 reads 0x000000DE.
- Simultaneous req0/req1 loads from reset → port 0 acked first, port 1 acked 3 cycles later. On the next tie, port 0 wins again because last_grant=1.
- Boundary accesses:
  - word load at addr 252 → ok.
  - word load at 253 → ack at N+1, err=1, rdata=0.
  - half store at 255 → err, memory unchanged.
  - addr 0xFFFFFFFC word → err.
- rst pulse while in WRITE (before negedge) of store 0x12345678 to 0x20 → memory at 0x20 unchanged, no ack, all outputs at reset values.
- size=11 on port 1 → err ack1 at N+1, mem_wr never asserted.
